// File: rtl/mem_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
// Holds the FSM state encoding and the address-region decode.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    REG_RAM      = 2'd0,
    REG_IO       = 2'd1,
    REG_UNMAPPED = 2'd2
  } mem_region_t;

  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  // IO_ADDR wins over the RAM window, so this also holds when ADDR_W is 16.
  function automatic mem_region_t decode_region(input logic [15:0] addr,
                                                input int          addr_w);
    logic [31:0] w_high;
    w_high = {16'h0000, addr} >> addr_w;
    if (addr == IO_ADDR) begin
      return REG_IO;
    end else if (w_high == 32'd0) begin
      return REG_RAM;
    end else begin
      return REG_UNMAPPED;
    end
  endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, 16-bit words, registered read-first output.
// The registered read lets synthesis map it onto block RAM.
module ram_sp #(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       din,
  output logic [15:0]       dout
);

  logic [15:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge Clk) begin
    if (we) begin
      r_mem[addr] <= din;
    end
    dout <= r_mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the SLC-3 memory port: on-chip RAM, switch/hex I/O
// at IO_ADDR, and a programmable number of wait states before each completion.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req,
  input  logic       WE,
  input  logic [15:0] Addr,
  input  logic [15:0] Wdata,
  input  logic [15:0] Switches,
  output logic [15:0] Rdata,
  output logic       Ready,
  output logic       Err,
  output logic [15:0] Hex_Out,
  output mem_state_t o_dbg_state
);

  // Handshake: the initiator raises Req with WE/Addr/Wdata and holds them until
  // the one-cycle Ready pulse; the request is captured in IDLE and never
  // re-sampled until the FSM returns to IDLE after DONE.

  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  mem_state_t  r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [15:0] r_addr, r_wdata;
  logic        r_we;
  logic        w_access;

  logic [15:0] w_cur_addr, w_cur_wdata;
  logic        w_cur_we;
  mem_region_t w_region;

  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [15:0]       w_ram_dout;

  logic [15:0] r_rdata;
  logic        r_rdata_from_ram;
  logic        r_ready, r_err;
  logic [15:0] r_hex;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // w_access marks the cycle whose closing edge is the DONE entry edge.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_access     = 1'b0;
    case (r_state)
      IDLE: begin
        if (Req) begin
          if (WAIT_STATES == 0) begin
            w_state_next = DONE;
            w_access     = 1'b1;
          end else begin
            w_state_next = BUSY;
            w_cnt_next   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_next = DONE;
          w_access     = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // With zero wait states the access happens on the sampling edge itself,
  // so the live inputs are used instead of the latched copies.
  always_comb begin
    w_cur_addr  = r_addr;
    w_cur_wdata = r_wdata;
    w_cur_we    = r_we;
    if (r_state == IDLE) begin
      w_cur_addr  = Addr;
      w_cur_wdata = Wdata;
      w_cur_we    = WE;
    end
  end

  assign w_region   = decode_region(w_cur_addr, ADDR_W);
  assign w_ram_addr = w_cur_addr[ADDR_W-1:0];
  assign w_ram_we   = w_access && w_cur_we && (w_region == REG_RAM);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_we    <= 1'b0;
    end else if (r_state == IDLE && Req) begin
      r_addr  <= Addr;
      r_wdata <= Wdata;
      r_we    <= WE;
    end
  end

  ram_sp #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .Clk (Clk),
    .we  (w_ram_we),
    .addr(w_ram_addr),
    .din (w_cur_wdata),
    .dout(w_ram_dout)
  );

  // A RAM read lands in the RAM output register on the DONE entry edge; Rdata
  // selects it during DONE and the value is copied into r_rdata on DONE exit.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rdata          <= 16'h0000;
      r_rdata_from_ram <= 1'b0;
      r_ready          <= 1'b0;
      r_err            <= 1'b0;
      r_hex            <= 16'h0000;
    end else begin
      r_ready <= w_access;
      r_err   <= w_access && (w_region == REG_UNMAPPED);
      if (w_access && !w_cur_we) begin
        case (w_region)
          REG_RAM: r_rdata_from_ram <= 1'b1;
          REG_IO: begin
            r_rdata          <= Switches;
            r_rdata_from_ram <= 1'b0;
          end
          default: begin
            r_rdata          <= 16'h0000;
            r_rdata_from_ram <= 1'b0;
          end
        endcase
      end else if (r_rdata_from_ram) begin
        r_rdata          <= w_ram_dout;
        r_rdata_from_ram <= 1'b0;
      end
      if (w_access && w_cur_we && (w_region == REG_IO)) begin
        r_hex <= w_cur_wdata;
      end
    end
  end

  assign Rdata       = r_rdata_from_ram ? w_ram_dout : r_rdata;
  assign Ready       = r_ready;
  assign Err         = r_err;
  assign Hex_Out     = r_hex;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_STATES=2 instance for the main
// checks and a WAIT_STATES=0 instance for latency/throughput.
module tb_mem_responder;
  import mem_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        Req, WE;
  logic [15:0] Addr, Wdata, Switches;
  logic [15:0] Rdata, Hex_Out;
  logic        Ready, Err;
  mem_state_t  dbg_state;

  logic        z_Req, z_WE;
  logic [15:0] z_Addr, z_Wdata;
  logic [15:0] z_Rdata, z_Hex_Out;
  logic        z_Ready, z_Err;
  mem_state_t  z_dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  mem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .WE(WE), .Addr(Addr), .Wdata(Wdata),
    .Switches(Switches), .Rdata(Rdata), .Ready(Ready), .Err(Err),
    .Hex_Out(Hex_Out), .o_dbg_state(dbg_state)
  );

  mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Req(z_Req), .WE(z_WE), .Addr(z_Addr), .Wdata(z_Wdata),
    .Switches(Switches), .Rdata(z_Rdata), .Ready(z_Ready), .Err(z_Err),
    .Hex_Out(z_Hex_Out), .o_dbg_state(z_dbg_state)
  );

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic access2(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         output logic [15:0] rdata, output logic err, output int lat);
    @(negedge Clk);
    Req = 1'b1; WE = we; Addr = addr; Wdata = wdata;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk); #1;
      if (Ready) begin
        lat = i;
        break;
      end
    end
    rdata = Rdata;
    err   = Err;
    Req = 1'b0; WE = 1'b0;
    @(posedge Clk); #1;
    check_eq("ready_one_cycle", {31'd0, Ready}, 32'd0);
  endtask

  task automatic access0(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         output logic [15:0] rdata, output int lat);
    @(negedge Clk);
    z_Req = 1'b1; z_WE = we; z_Addr = addr; z_Wdata = wdata;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk); #1;
      if (z_Ready) begin
        lat = i;
        break;
      end
    end
    rdata = z_Rdata;
    z_Req = 1'b0; z_WE = 1'b0;
    @(posedge Clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;
    int          n_rdy;
    logic [11:0] pat;

    Reset = 1'b0; Req = 1'b0; WE = 1'b0; Addr = 16'h0; Wdata = 16'h0;
    z_Req = 1'b0; z_WE = 1'b0; z_Addr = 16'h0; z_Wdata = 16'h0;
    Switches = 16'h5A5A;
    #23;
    check_eq("rst_rdata", {16'd0, Rdata}, 32'h0);
    check_eq("rst_ready", {31'd0, Ready}, 32'h0);
    check_eq("rst_err", {31'd0, Err}, 32'h0);
    check_eq("rst_hex", {16'd0, Hex_Out}, 32'h0);
    check_eq("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    @(negedge Clk); Reset = 1'b1;

    // RAM write then read, 3-cycle latency each
    access2(1'b1, 16'h0005, 16'h1234, rd, er, lat);
    check_eq("wr5_lat", lat, 3);
    check_eq("wr5_err", {31'd0, er}, 0);
    check_eq("wr5_rdata_kept", {16'd0, rd}, 32'h0);
    access2(1'b0, 16'h0005, 16'h0000, rd, er, lat);
    check_eq("rd5_lat", lat, 3);
    check_eq("rd5_data", {16'd0, rd}, 32'h1234);
    check_eq("rd5_err", {31'd0, er}, 0);
    check_eq("rd5_hold", {16'd0, Rdata}, 32'h1234);
    access2(1'b1, 16'h0000, 16'h0C0C, rd, er, lat);
    check_eq("wr0_rdata_kept", {16'd0, rd}, 32'h1234);

    // IO write / read
    access2(1'b1, 16'hFFFF, 16'h00AB, rd, er, lat);
    check_eq("io_wr_hex", {16'd0, Hex_Out}, 32'h00AB);
    check_eq("io_wr_err", {31'd0, er}, 0);
    access2(1'b0, 16'hFFFF, 16'h0000, rd, er, lat);
    check_eq("io_rd_data", {16'd0, rd}, 32'h5A5A);
    check_eq("io_rd_hex_kept", {16'd0, Hex_Out}, 32'h00AB);

    // unmapped
    access2(1'b0, 16'h8000, 16'h0000, rd, er, lat);
    check_eq("unm_rd_data", {16'd0, rd}, 32'h0);
    check_eq("unm_rd_err", {31'd0, er}, 1);
    check_eq("unm_err_pulse", {31'd0, Err}, 0);
    access2(1'b1, 16'h8000, 16'hFFFF, rd, er, lat);
    check_eq("unm_wr_err", {31'd0, er}, 1);
    check_eq("unm_wr_hex", {16'd0, Hex_Out}, 32'h00AB);
    access2(1'b0, 16'h0000, 16'h0000, rd, er, lat);
    check_eq("unm_wr_ram0", {16'd0, rd}, 32'h0C0C);
    access2(1'b0, 16'h0005, 16'h0000, rd, er, lat);
    check_eq("unm_wr_ram5", {16'd0, rd}, 32'h1234);

    // zero wait states
    access0(1'b1, 16'h0000, 16'hBEEF, rd, lat);
    check_eq("w0_wr_lat", lat, 1);
    access0(1'b0, 16'h0000, 16'h0000, rd, lat);
    check_eq("w0_rd_lat", lat, 1);
    check_eq("w0_rd_data", {16'd0, rd}, 32'hBEEF);
    @(negedge Clk);
    z_Req = 1'b1; z_WE = 1'b0; z_Addr = 16'h0000;
    pat = 12'd0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      pat[i] = z_Ready;
    end
    z_Req = 1'b0;
    check_eq("w0_b2b_pattern", {20'd0, pat}, 32'h555);
    check_eq("w0_b2b_data", {16'd0, z_Rdata}, 32'hBEEF);
    repeat (2) @(posedge Clk);

    // reset during BUSY aborts the write
    access2(1'b1, 16'h0003, 16'h1111, rd, er, lat);
    @(negedge Clk);
    Req = 1'b1; WE = 1'b1; Addr = 16'h0003; Wdata = 16'h7777;
    @(posedge Clk); @(posedge Clk); #2;
    check_eq("rst_mid_busy", {30'd0, dbg_state}, {30'd0, BUSY});
    Reset = 1'b0;
    #1;
    Req = 1'b0; WE = 1'b0;
    check_eq("rst_mid_idle", {30'd0, dbg_state}, {30'd0, IDLE});
    @(negedge Clk); Reset = 1'b1;
    n_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      if (Ready) n_rdy++;
    end
    check_eq("rst_mid_no_ready", n_rdy, 0);
    check_eq("rst_mid_hex", {16'd0, Hex_Out}, 32'h0);
    access2(1'b0, 16'h0003, 16'h0000, rd, er, lat);
    check_eq("rst_mid_ram3", {16'd0, rd}, 32'h1111);

    // Req dropped after one BUSY cycle
    @(negedge Clk);
    Req = 1'b1; WE = 1'b0; Addr = 16'h0005;
    @(posedge Clk); @(posedge Clk);
    @(negedge Clk); Req = 1'b0;
    n_rdy = 0;
    rd = 16'h0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      if (Ready) begin
        n_rdy++;
        rd = Rdata;
      end
    end
    check_eq("drop_ready_count", n_rdy, 1);
    check_eq("drop_data", {16'd0, rd}, 32'h1234);
    check_eq("drop_state", {30'd0, dbg_state}, {30'd0, IDLE});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
